// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the instruction sequencer and its datapath.
//   state_t      : sequencer FSM states (3-bit encoding)
//   mem_src_t    : source select for the shared memory port address/data
//   ADDR_W/DATA_W: default memory address / data widths
//   INITIAL_ADDR : first fetch address, shared with the datapath PC reset
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] INITIAL_ADDR = ADDR_W'(16);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM_LD = 3'd3,
        ST_MEM_ST = 3'd4,
        ST_EXEC   = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_PC = 2'd0,
        SRC_LD = 2'd1,
        SRC_ST = 2'd2
    } mem_src_t;

    // States in which the memory port carries an outstanding request.
    function automatic logic is_req_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_LD) || (s == ST_MEM_ST);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Shared memory port: a single req/ack channel carrying both instruction
// fetches and load/store traffic.
//   mem_req   : request valid, held until mem_ack
//   mem_we    : 1 = store, 0 = read
//   mem_addr  : request address, stable while mem_req = 1
//   mem_wdata : store data, stable while mem_req = 1
//   mem_ack   : completion; mem_rdata valid in the same cycle
//   mem_rdata : read data
// master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = seq_pkg::ADDR_W,
    parameter int unsigned DATA_W = seq_pkg::DATA_W
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_mux.sv
// ---------------------------------------------------------------------------
// mem_port_mux
// Registers the memory request address, write enable and store data when the
// sequencer launches a request, so the bus stays stable for the whole
// request regardless of what the datapath does meanwhile.
//   clk, rst    : clock, async active-high reset
//   i_launch    : one-cycle strobe, capture on this edge
//   i_src       : which source to capture (PC fetch, load, store)
//   i_pc        : fetch address
//   i_ls_addr   : load/store address
//   i_st_data   : store data
//   o_addr      : registered request address
//   o_we        : registered write enable
//   o_wdata     : registered store data
// ---------------------------------------------------------------------------
module mem_port_mux
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W = seq_pkg::ADDR_W,
    parameter int unsigned DATA_W = seq_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_launch,
    input  mem_src_t          i_src,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_st_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic [DATA_W-1:0] o_wdata
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;

    // Capture request fields only at launch; store data is left alone on reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (i_launch) begin
            unique case (i_src)
                SRC_PC: begin
                    r_addr <= i_pc;
                    r_we   <= 1'b0;
                end
                SRC_LD: begin
                    r_addr <= i_ls_addr;
                    r_we   <= 1'b0;
                end
                SRC_ST: begin
                    r_addr  <= i_ls_addr;
                    r_we    <= 1'b1;
                    r_wdata <= i_st_data;
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

    assign o_addr  = r_addr;
    assign o_we    = r_we;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle fetch/decode/execute controller. Owns the shared memory port,
// latches the fetched instruction and load data, and produces the datapath
// ld / commit / pc_inc strobes.
//   clk             : system clock
//   reset_n         : async reset, active HIGH despite the name
//   program_counter : fetch address from the datapath
//   mem_loca        : load/store address from the datapath
//   st_data         : store data from the datapath
//   dec_is_load/dec_is_store/dec_halt : decoder flags, sampled in DECODE
//   mem             : shared memory port (master side)
//   instr           : latched instruction for the decoder
//   ld, ld_data     : load-data select and latched load data
//   commit, pc_inc  : one-cycle writeback / PC-advance strobes (EXEC)
//   halted, fault   : sticky halt and illegal-decode flags
// ---------------------------------------------------------------------------
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W = seq_pkg::ADDR_W,
    parameter int unsigned DATA_W = seq_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   program_counter,
    input  logic [ADDR_W-1:0]   mem_loca,
    input  logic [DATA_W-1:0]   st_data,
    input  logic                dec_is_load,
    input  logic                dec_is_store,
    input  logic                dec_halt,
    instr_sequencer_if.master   mem,
    output logic [DATA_W-1:0]   instr,
    output logic                ld,
    output logic [DATA_W-1:0]   ld_data,
    output logic                commit,
    output logic                pc_inc,
    output logic                halted,
    output logic                fault
);

    state_t            r_state;
    state_t            w_next;

    logic              w_launch;
    mem_src_t          w_src;
    logic              w_fault_set;
    logic              w_instr_we;
    logic              w_ld_data_we;
    logic              w_req_nxt;
    logic              w_commit_nxt;
    logic              w_ld_nxt;
    logic              w_halted_nxt;

    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_ld_data;
    logic              r_req;
    logic              r_commit;
    logic              r_ld;
    logic              r_halted;
    logic              r_fault;

    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;

    // State register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and registered-output decode. Outputs are computed from the
    // next state so they line up with the state they belong to.
    always_comb begin
        w_next       = r_state;
        w_launch     = 1'b0;
        w_src        = SRC_PC;
        w_fault_set  = 1'b0;
        w_instr_we   = 1'b0;
        w_ld_data_we = 1'b0;

        unique case (r_state)
            ST_RST: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem.mem_ack) begin
                    w_instr_we = 1'b1;
                    w_next     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    w_next = ST_HALT;
                end else if (dec_is_load && dec_is_store) begin
                    w_fault_set = 1'b1;
                    w_next      = ST_HALT;
                end else if (dec_is_load) begin
                    w_next = ST_MEM_LD;
                end else if (dec_is_store) begin
                    w_next = ST_MEM_ST;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_MEM_LD: begin
                if (mem.mem_ack) begin
                    w_ld_data_we = 1'b1;
                    w_next       = ST_EXEC;
                end
            end
            ST_MEM_ST: begin
                if (mem.mem_ack) begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_RST;
            end
        endcase

        // Launch the port registers only on entry to a request state.
        if (w_next != r_state) begin
            unique case (w_next)
                ST_FETCH: begin
                    w_launch = 1'b1;
                    w_src    = SRC_PC;
                end
                ST_MEM_LD: begin
                    w_launch = 1'b1;
                    w_src    = SRC_LD;
                end
                ST_MEM_ST: begin
                    w_launch = 1'b1;
                    w_src    = SRC_ST;
                end
                default: begin
                    w_launch = 1'b0;
                end
            endcase
        end

        w_req_nxt    = is_req_state(w_next);
        w_commit_nxt = (w_next == ST_EXEC);
        // EXEC reached from MEM_LD is the load's writeback cycle.
        w_ld_nxt     = (w_next == ST_MEM_LD) ||
                       ((w_next == ST_EXEC) && (r_state == ST_MEM_LD));
        w_halted_nxt = (w_next == ST_HALT);
    end

    // Registered outputs and data latches; reset clears everything at once,
    // which also abandons any outstanding request.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_instr   <= '0;
            r_ld_data <= '0;
            r_req     <= 1'b0;
            r_commit  <= 1'b0;
            r_ld      <= 1'b0;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            if (w_instr_we) begin
                r_instr <= mem.mem_rdata;
            end
            if (w_ld_data_we) begin
                r_ld_data <= mem.mem_rdata;
            end
            r_req    <= w_req_nxt;
            r_commit <= w_commit_nxt;
            r_ld     <= w_ld_nxt;
            r_halted <= w_halted_nxt;
            r_fault  <= r_fault | w_fault_set;
        end
    end

    mem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_port_mux (
        .clk       (clk),
        .rst       (reset_n),
        .i_launch  (w_launch),
        .i_src     (w_src),
        .i_pc      (program_counter),
        .i_ls_addr (mem_loca),
        .i_st_data (st_data),
        .o_addr    (w_addr),
        .o_we      (w_we),
        .o_wdata   (w_wdata)
    );

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_wdata = w_wdata;

    assign instr   = r_instr;
    assign ld      = r_ld;
    assign ld_data = r_ld_data;
    assign commit  = r_commit;
    assign pc_inc  = r_commit;
    assign halted  = r_halted;
    assign fault   = r_fault;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer: the bench plays memory and decoder.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;
    import seq_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] program_counter;
    logic [ADDR_W-1:0] mem_loca;
    logic [DATA_W-1:0] st_data;
    logic              dec_is_load;
    logic              dec_is_store;
    logic              dec_halt;
    logic [DATA_W-1:0] instr;
    logic              ld;
    logic [DATA_W-1:0] ld_data;
    logic              commit;
    logic              pc_inc;
    logic              halted;
    logic              fault;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_commit = 0;
    int c0       = 0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    instr_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .program_counter (program_counter),
        .mem_loca        (mem_loca),
        .st_data         (st_data),
        .dec_is_load     (dec_is_load),
        .dec_is_store    (dec_is_store),
        .dec_halt        (dec_halt),
        .mem             (mem_bus),
        .instr           (instr),
        .ld              (ld),
        .ld_data         (ld_data),
        .commit          (commit),
        .pc_inc          (pc_inc),
        .halted          (halted),
        .fault           (fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and tally commit pulses.
    task automatic step();
        @(negedge clk);
        if (commit === 1'b1) n_commit++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n           = 1'b1;
        program_counter   = INITIAL_ADDR;
        mem_loca          = '0;
        st_data           = '0;
        dec_is_load       = 1'b0;
        dec_is_store      = 1'b0;
        dec_halt          = 1'b0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        step();
        step();
        check_eq("rst_req",    32'(mem_bus.mem_req), 32'h0);
        check_eq("rst_addr",   mem_bus.mem_addr, 32'h0);
        check_eq("rst_instr",  instr, 32'h0);
        check_eq("rst_commit", 32'(commit), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_fault",  32'(fault), 32'h0);

        // ALU instruction, zero-wait fetch
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h1234_5678;
        reset_n           = 1'b0;
        step();
        check_eq("alu_req_c1",  32'(mem_bus.mem_req), 32'h1);
        check_eq("alu_addr_c1", mem_bus.mem_addr, 32'h10);
        check_eq("alu_we_c1",   32'(mem_bus.mem_we), 32'h0);
        check_eq("alu_commit_c1", 32'(commit), 32'h0);
        step();
        check_eq("alu_instr",     instr, 32'h1234_5678);
        check_eq("alu_req_c2",    32'(mem_bus.mem_req), 32'h0);
        check_eq("alu_commit_c2", 32'(commit), 32'h0);
        mem_bus.mem_ack = 1'b0;
        step();
        check_eq("alu_commit_c3", 32'(commit), 32'h1);
        check_eq("alu_pcinc_c3",  32'(pc_inc), 32'h1);
        check_eq("alu_ld_c3",     32'(ld), 32'h0);
        step();
        check_eq("alu_commit_c4", 32'(commit), 32'h0);
        check_eq("alu_pcinc_c4",  32'(pc_inc), 32'h0);
        check_eq("nxt_fetch_req", 32'(mem_bus.mem_req), 32'h1);

        // Load with ack delayed three cycles
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0001;
        dec_is_load       = 1'b1;
        mem_loca          = 32'h40;
        step();
        check_eq("ld_instr", instr, 32'h1);
        mem_bus.mem_ack = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("ld_req",  32'(mem_bus.mem_req), 32'h1);
            check_eq("ld_addr", mem_bus.mem_addr, 32'h40);
            check_eq("ld_we",   32'(mem_bus.mem_we), 32'h0);
            check_eq("ld_ld",   32'(ld), 32'h1);
            mem_loca = 32'h99;
            if (i == 3) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = 32'hCAFE_F00D;
            end else begin
                mem_bus.mem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        mem_bus.mem_ack = 1'b0;
        dec_is_load     = 1'b0;
        check_eq("ld_data",      ld_data, 32'hCAFE_F00D);
        check_eq("ld_exec_ld",   32'(ld), 32'h1);
        check_eq("ld_commit",    32'(commit), 32'h1);
        check_eq("ld_exec_req",  32'(mem_bus.mem_req), 32'h0);
        step();

        // Store, st_data/mem_loca disturbed mid-wait
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0002;
        dec_is_store      = 1'b1;
        mem_loca          = 32'h80;
        st_data           = 32'hA5A5_A5A5;
        step();
        mem_bus.mem_ack = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("st_req",   32'(mem_bus.mem_req), 32'h1);
            check_eq("st_we",    32'(mem_bus.mem_we), 32'h1);
            check_eq("st_addr",  mem_bus.mem_addr, 32'h80);
            check_eq("st_wdata", mem_bus.mem_wdata, 32'hA5A5_A5A5);
            st_data  = '0;
            mem_loca = '0;
            if (i == 2) mem_bus.mem_ack = 1'b1;
            step();
        end
        mem_bus.mem_ack = 1'b0;
        dec_is_store    = 1'b0;
        check_eq("st_commit",  32'(commit), 32'h1);
        check_eq("st_ld",      32'(ld), 32'h0);
        check_eq("st_ld_data", ld_data, 32'hCAFE_F00D);
        step();

        // Halt with spurious acks
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0003;
        dec_halt          = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        step();
        check_eq("halt_halted", 32'(halted), 32'h1);
        check_eq("halt_fault",  32'(fault), 32'h0);
        c0 = n_commit;
        for (int i = 0; i < 20; i++) begin
            mem_bus.mem_ack = 1'((i & 1) == 0);
            step();
            check_eq("halt_req", 32'(mem_bus.mem_req), 32'h0);
        end
        check_eq("halt_sticky", 32'(halted), 32'h1);
        check_eq("halt_commits", 32'(n_commit - c0), 32'h0);
        dec_halt        = 1'b0;
        mem_bus.mem_ack = 1'b0;

        // Illegal decode: load and store together
        #2 reset_n = 1'b1;
        #1;
        check_eq("rst2_halted", 32'(halted), 32'h0);
        step();
        reset_n           = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0004;
        dec_is_load       = 1'b1;
        dec_is_store      = 1'b1;
        c0                = n_commit;
        step();
        step();
        step();
        check_eq("flt_fault",  32'(fault), 32'h1);
        check_eq("flt_halted", 32'(halted), 32'h1);
        repeat (4) step();
        check_eq("flt_commits", 32'(n_commit - c0), 32'h0);
        check_eq("flt_req",     32'(mem_bus.mem_req), 32'h0);

        // Reset during a load wait
        #2 reset_n = 1'b1;
        #1;
        check_eq("rst3_fault", 32'(fault), 32'h0);
        step();
        reset_n           = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0005;
        dec_is_store      = 1'b0;
        dec_is_load       = 1'b1;
        mem_loca          = 32'h40;
        step();
        step();
        mem_bus.mem_ack = 1'b0;
        step();
        check_eq("rld_req",  32'(mem_bus.mem_req), 32'h1);
        check_eq("rld_addr", mem_bus.mem_addr, 32'h40);
        step();
        c0 = n_commit;
        #2 reset_n = 1'b1;
        #1;
        check_eq("rld_req_drop", 32'(mem_bus.mem_req), 32'h0);
        check_eq("rld_commit",   32'(commit), 32'h0);
        check_eq("rld_ld",       32'(ld), 32'h0);
        step();
        reset_n     = 1'b0;
        dec_is_load = 1'b0;
        step();
        check_eq("rld_refetch_req",  32'(mem_bus.mem_req), 32'h1);
        check_eq("rld_refetch_addr", mem_bus.mem_addr, 32'h10);
        check_eq("rld_no_commit",    32'(n_commit - c0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
